uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_pkg.sv | 16 +
 rtl/uart_bus_master.sv | 133 +++++++++++++
 tb/tb_uart_bus_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: shared FSM encoding, phase-counter type and register map
package uart_bus_pkg;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 4;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_e;
  localparam addr_t REG_CTRL   = addr_t'(0);
  localparam addr_t REG_STATUS = addr_t'(1);
  localparam addr_t REG_DATA   = addr_t'(3);
  localparam addr_t REG_IRQ    = addr_t'(4);
  // Counter reload for a phase lasting p cycles; 0 behaves as 1, oversize saturates
  function automatic cnt_t phase_load(int p);
    return cnt_t'((p < 1) ? 0 : ((p > 16) ? 15 : p - 1));
  endfunction
endpackage

// File: rtl/uart_bus_master.sv
// uart_bus_master: turns single-beat requests into timed chip-select/strobe bus cycles
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [3:0]  req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_write_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [3:0]  AddrBus_o,
  output logic        n_ChipSelect_o,
  output logic        n_rd_o,
  output logic        n_we_o,
  output logic [7:0]  DataBus_o,
  input  logic [7:0]  DataBus_i,
  input  logic        p_IrqSig_i,
  output logic        p_IrqRise_o
);
  localparam cnt_t SETUP_LD  = phase_load(SETUP_CYC);
  localparam cnt_t STROBE_LD = phase_load(STROBE_CYC);
  localparam cnt_t HOLD_LD   = phase_load(HOLD_CYC);
  state_e      state_q;
  cnt_t        cnt_q, cnt_d;
  logic        pend_q, write_q, last_d;
  addr_t       addr_q, abus_q;
  logic [7:0]  wdata_q, dbus_q, rdata_q;
  logic        n_cs_q, n_rd_q, n_we_q, rsp_valid_q, rsp_write_q;
  logic        irq_q, rise_q, rise_d;
  assign cnt_d  = cnt_q - cnt_t'(1);
  assign last_d = (cnt_q == '0);
  assign rise_d = p_IrqSig_i & ~irq_q;
  // Ready is dropped while the accepted request waits one cycle to launch, and at once by reset
  assign req_ready_o    = rst & (state_q == IDLE) & ~pend_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_write_o    = rsp_write_q;
  assign rsp_rdata_o    = rdata_q;
  assign AddrBus_o      = abus_q;
  assign n_ChipSelect_o = n_cs_q;
  assign n_rd_o         = n_rd_q;
  assign n_we_o         = n_we_q;
  assign DataBus_o      = dbus_q;
  assign p_IrqRise_o    = rise_q;
  // Bus-cycle FSM; every phase reloads the shared down-counter and leaves when it hits zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      n_cs_q      <= 1'b1;
      n_rd_q      <= 1'b1;
      n_we_q      <= 1'b1;
      abus_q      <= '0;
      dbus_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q <= SETUP;
            cnt_q   <= SETUP_LD;
            pend_q  <= 1'b0;
            n_cs_q  <= 1'b0;
            abus_q  <= addr_q;
            dbus_q  <= write_q ? wdata_q : 8'h00;
          end else if (req_valid_i) begin
            pend_q  <= 1'b1;
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
          end
        end
        SETUP: begin
          if (last_d) begin
            state_q <= STROBE;
            cnt_q   <= STROBE_LD;
            n_rd_q  <= write_q;
            n_we_q  <= ~write_q;
          end else cnt_q <= cnt_d;
        end
        STROBE: begin
          if (last_d) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            n_rd_q  <= 1'b1;
            n_we_q  <= 1'b1;
            if (!write_q) rdata_q <= DataBus_i;
          end else cnt_q <= cnt_d;
        end
        HOLD: begin
          if (last_d) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            n_cs_q      <= 1'b1;
            abus_q      <= '0;
            dbus_q      <= 8'h00;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= write_q;
          end else cnt_q <= cnt_d;
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Interrupt rising-edge detector, independent of the bus FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      irq_q  <= p_IrqSig_i;
      rise_q <= rise_d;
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
`timescale 1ns/1ps
// tb_uart_bus_master: three parameterisations driven by directed and random bus transactions
module tb_uart_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_write, irq;
  logic [3:0] req_addr;
  logic [7:0] req_wdata, dbin;
  logic vld[3], rdy[3], rsp_v[3], rsp_w[3], cs_n[3], rd_n[3], we_n[3], irq_r[3];
  logic [3:0] abus[3];
  logic [7:0] dbus[3], rdata[3];
  logic [7:0] exp_rdata[3];
  int se[3] = '{1, 15, 1};
  int te[3] = '{2, 15, 2};
  int he[3] = '{1, 15, 1};
  int total = 0, bad = 0, cyc = 0;
  int irq_hi[3] = '{0, 0, 0};
  int irq_runs[3] = '{0, 0, 0};
  logic irq_prev[3] = '{1'b0, 1'b0, 1'b0};
  int acc_cyc, rsp_cyc;

  for (genvar g = 0; g < 3; g++) begin : gd
    uart_bus_master #(
      .SETUP_CYC (g == 1 ? 15 : (g == 2 ? 0 : 1)),
      .STROBE_CYC(g == 1 ? 15 : 2),
      .HOLD_CYC  (g == 1 ? 15 : 1)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(vld[g]), .req_ready_o(rdy[g]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_v[g]), .rsp_write_o(rsp_w[g]), .rsp_rdata_o(rdata[g]),
      .AddrBus_o(abus[g]), .n_ChipSelect_o(cs_n[g]), .n_rd_o(rd_n[g]), .n_we_o(we_n[g]),
      .DataBus_o(dbus[g]), .DataBus_i(dbin),
      .p_IrqSig_i(irq), .p_IrqRise_o(irq_r[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (irq_r[i] === 1'b1) irq_hi[i] <= irq_hi[i] + 1;
      if (irq_r[i] === 1'b1 && irq_prev[i] !== 1'b1) irq_runs[i] <= irq_runs[i] + 1;
      irq_prev[i] <= irq_r[i];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on instance i, scored against the phase model built from se/te/he
  task automatic txn(input int i, input logic wr, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] rv, input logic keep);
    int k, w, cs_lo, rd_lo, we_lo, both, abad, dbad, cs_first, st_first, st_last, rsp_k;
    logic [7:0] dx;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = d; vld[i] = 1'b1;
    w = 0;
    while (rdy[i] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    chk("accept", 32'(w < 200), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep) vld[i] = 1'b0;
    k = 0; cs_lo = 0; rd_lo = 0; we_lo = 0; both = 0; abad = 0; dbad = 0;
    cs_first = -1; st_first = -1; st_last = -1; rsp_k = -1;
    dx = wr ? d : 8'h00;
    if (!wr) exp_rdata[i] = rv;
    while (rsp_k < 0 && k < 100) begin
      if (cs_n[i] === 1'b0) begin
        cs_lo++;
        if (cs_first < 0) cs_first = k;
        if (abus[i] !== a) abad++;
        if (dbus[i] !== dx) dbad++;
      end else if (dbus[i] !== 8'h00) dbad++;
      if (rd_n[i] === 1'b0) rd_lo++;
      if (we_n[i] === 1'b0) we_lo++;
      if (rd_n[i] === 1'b0 && we_n[i] === 1'b0) both++;
      if (rd_n[i] === 1'b0 || we_n[i] === 1'b0) begin
        if (st_first < 0) st_first = k;
        st_last = k;
      end
      dbin = (rd_n[i] === 1'b0) ? rv : ~rv;
      if (rsp_v[i] === 1'b1) begin
        rsp_k = k;
        rsp_cyc = cyc;
        chk("rsp_write", rsp_w[i], wr);
        chk("rsp_rdata", rdata[i], exp_rdata[i]);
        chk("rsp_cs_high", cs_n[i], 1);
      end else begin
        @(posedge clk); #1; k++;
      end
    end
    chk("latency", rsp_k + 1, 2 + se[i] + te[i] + he[i]);
    chk("cs_start", cs_first, 1);
    chk("cs_width", cs_lo, se[i] + te[i] + he[i]);
    chk("strobe_start", st_first, se[i] + 1);
    chk("strobe_span", st_last - st_first + 1, te[i]);
    chk("rd_width", rd_lo, wr ? 0 : te[i]);
    chk("we_width", we_lo, wr ? te[i] : 0);
    chk("strobes_overlap", both, 0);
    chk("addr_stable", abad, 0);
    chk("wdata_stable", dbad, 0);
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp_v[i], 0);
    chk("idle_cs_high", cs_n[i], 1);
    chk("idle_ready", rdy[i], 1);
  endtask

  initial begin
    int r1, w, exp_rise, lvl, nl, inst;
    int b_runs[3], b_hi[3];
    for (int i = 0; i < 3; i++) begin vld[i] = 1'b0; exp_rdata[i] = 8'h00; end
    req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00; dbin = 8'h00; irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs", cs_n[i], 1);
      chk("rst_rd", rd_n[i], 1);
      chk("rst_we", we_n[i], 1);
      chk("rst_addr", abus[i], 0);
      chk("rst_dbus", dbus[i], 0);
      chk("rst_rsp_valid", rsp_v[i], 0);
      chk("rst_rsp_write", rsp_w[i], 0);
      chk("rst_rdata", rdata[i], 0);
      chk("rst_irq_rise", irq_r[i], 0);
      chk("rst_ready", rdy[i], 0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", rdy[0], 1);

    txn(0, 1'b1, 4'h3, 8'hA5, 8'h00, 1'b0);
    txn(0, 1'b0, 4'h1, 8'h00, 8'h5C, 1'b0);
    txn(0, 1'b1, 4'h6, 8'h5A, 8'h00, 1'b1);
    r1 = rsp_cyc;
    txn(0, 1'b0, 4'hE, 8'h00, 8'hC3, 1'b0);
    chk("b2b_gap", acc_cyc - r1, 2);
    txn(1, 1'b1, 4'hF, 8'h81, 8'h00, 1'b0);
    txn(1, 1'b0, 4'h2, 8'h00, 8'h7E, 1'b0);
    txn(2, 1'b1, 4'h4, 8'h11, 8'h00, 1'b0);
    txn(2, 1'b0, 4'h8, 8'h00, 8'hE7, 1'b0);

    for (int n = 0; n < 24; n++) begin
      inst = (n % 8 == 7) ? 1 : ((n % 3 == 2) ? 2 : 0);
      txn(inst, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin b_runs[i] = irq_runs[i]; b_hi[i] = irq_hi[i]; end
    fork
      txn(1, 1'b0, 4'hC, 8'h00, 8'h96, 1'b0);
      begin
        @(negedge clk); irq = 1'b0;
        repeat (5) @(negedge clk); irq = 1'b1;
        repeat (6) @(negedge clk); irq = 1'b0;
        repeat (6) @(negedge clk); irq = 1'b1;
        repeat (6) @(negedge clk);
      end
    join
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("irq_pulses", irq_runs[i] - b_runs[i], 2);
      chk("irq_width", irq_hi[i] - b_hi[i], 2);
    end
    irq = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin b_runs[i] = irq_runs[i]; b_hi[i] = irq_hi[i]; end
    lvl = 0; exp_rise = 0;
    for (int n = 0; n < 30; n++) begin
      nl = int'($urandom_range(0, 1));
      if (nl == 1 && lvl == 0) exp_rise++;
      lvl = nl;
      irq = 1'(nl);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    if (lvl == 0) begin irq = 1'b1; exp_rise++; repeat (2) @(negedge clk); end
    irq = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("irq_rand_pulses", irq_runs[i] - b_runs[i], exp_rise);
      chk("irq_rand_width", irq_hi[i] - b_hi[i], exp_rise);
    end

    @(negedge clk);
    req_write = 1'b0; req_addr = 4'h7; req_wdata = 8'h00; dbin = 8'h3C; vld[0] = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_strobe2", rd_n[0], 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_cs", cs_n[0], 1);
    chk("arst_rd", rd_n[0], 1);
    chk("arst_we", we_n[0], 1);
    chk("arst_ready", rdy[0], 0);
    chk("arst_rsp", rsp_v[0], 0);
    chk("arst_rdata", rdata[0], 0);
    for (int i = 0; i < 3; i++) exp_rdata[i] = 8'h00;
    @(posedge clk); #1;
    chk("arst_hold_rsp", rsp_v[0], 0);
    chk("arst_hold_cs", cs_n[0], 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_reaccept", rdy[0], 0);
    chk("rst_no_rsp", rsp_v[0], 0);
    vld[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_setup", cs_n[0], 0);
    w = 0;
    while (rsp_v[0] !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    chk("rst_txn_done", 32'(w < 20), 1);
    chk("rst_txn_rdata", rdata[0], 8'h3C);
    chk("rst_other_rdata", rdata[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
